// File: rtl/dtw_ref_pkg.sv
// Shared definitions for the DTW reference-memory loader and reader.
// State encodings, memory read latency and block version fields.
package dtw_ref_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } ref_state_t;

    localparam int RD_LAT = 1;

    localparam logic [7:0] VER_MAJOR    = 8'd1;
    localparam logic [7:0] VER_MINOR    = 8'd0;
    localparam logic [7:0] VER_REVISION = 8'd0;

endpackage

// File: rtl/dtw_ref_fwft_buf.sv
// First-word-fall-through elastic buffer: head_data is valid whenever !empty.
// Push and pop in the same cycle leave the occupancy unchanged; flush empties it.
module dtw_ref_fwft_buf #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [WIDTH-1:0]       head_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; its contents are only observable behind count.
    always_ff @(posedge clk_in) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head_data = mem[rd_ptr];
    assign empty     = (count == '0);
    assign full      = (count == ($clog2(DEPTH)+1)'(DEPTH));

endmodule

// File: rtl/dtw_core_ref_reader.sv
// Streams reference memory words 0..len_eff-1 into a sink FIFO through a FWFT buffer.
// Optional running checksum output enabled by DTW_REF_READER_CKSUM_EN.
module dtw_core_ref_reader
    import dtw_ref_pkg::*;
#(
    parameter int DATA_WIDTH       = 16,
    parameter int ADDR_WIDTH       = 32,
    parameter int REFMEM_PTR_WIDTH = 20,
    parameter int BUF_DEPTH        = 4
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        rs_in,
    input  logic                        ref_load_done_in,
    input  logic [ADDR_WIDTH-1:0]       ref_len_in,
    output logic                        busy_out,
    output logic                        done_out,
    output logic [REFMEM_PTR_WIDTH-1:0] ref_addr_out,
    input  logic [DATA_WIDTH-1:0]       ref_data_in,
    output logic                        sink_fifo_wren_out,
    input  logic                        sink_fifo_full_in,
    output logic [DATA_WIDTH-1:0]       sink_fifo_data_out,
    output logic [1:0]                  dbg_state,
    output logic [31:0]                 dbg_word_cnt
`ifdef DTW_REF_READER_CKSUM_EN
    ,
    output logic [31:0]                 cksum_out
`endif
);

    localparam int                          CNT_W   = $clog2(BUF_DEPTH) + 1;
    localparam logic [63:0]                 LEN_CAP = 64'd1 << REFMEM_PTR_WIDTH;
    localparam logic [REFMEM_PTR_WIDTH:0]   PTR_ONE = 1;

    ref_state_t                  state, state_next;
    logic [REFMEM_PTR_WIDTH:0]   len_eff, len_eff_d;
    logic [REFMEM_PTR_WIDTH:0]   rd_issued;
    logic [REFMEM_PTR_WIDTH:0]   wr_cnt;
    logic                        addr_vld;
    logic                        data_vld;
    logic [63:0]                 len_wide;

    logic                        start, issue_start, issue, running, abort;
    logic                        wren, push;
    logic                        buf_empty, buf_full;
    logic [CNT_W-1:0]            buf_count;
    int                          occ_sum;

    assign len_wide  = 64'(ref_len_in);
    assign len_eff_d = (len_wide > LEN_CAP) ? LEN_CAP[REFMEM_PTR_WIDTH:0]
                                            : len_wide[REFMEM_PTR_WIDTH:0];

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) state <= IDLE;
        else         state <= state_next;
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_next  = state;
        start       = 1'b0;
        issue_start = 1'b0;
        issue       = 1'b0;
        running     = 1'b0;
        abort       = 1'b0;
        wren        = 1'b0;
        push        = 1'b0;
        occ_sum     = 0;
        case (state)
            IDLE: begin
                if (rs_in && ref_load_done_in) begin
                    start       = 1'b1;
                    issue_start = (len_eff_d != '0);
                    state_next  = issue_start ? STREAM : DONE;
                end
            end
            STREAM, DRAIN: begin
                running = rs_in;
                abort   = !rs_in;
                wren    = rs_in && !buf_empty && !sink_fifo_full_in;
                push    = rs_in && data_vld;
                // Issue credit: words already buffered plus reads still in flight.
                occ_sum = int'(buf_count) - int'(wren) + int'(addr_vld) + int'(data_vld);
                issue   = (state == STREAM) && rs_in && !buf_full &&
                          (rd_issued < len_eff) && (occ_sum < BUF_DEPTH);
                if (!rs_in)
                    state_next = IDLE;
                else if (state == STREAM && rd_issued == len_eff)
                    state_next = DRAIN;
                else if (state == DRAIN && !addr_vld && !data_vld && buf_empty &&
                         wr_cnt == len_eff)
                    state_next = DONE;
            end
            DONE: begin
                if (!rs_in) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            len_eff      <= '0;
            rd_issued    <= '0;
            wr_cnt       <= '0;
            ref_addr_out <= '0;
            addr_vld     <= 1'b0;
            data_vld     <= 1'b0;
        end else if (start) begin
            len_eff  <= len_eff_d;
            wr_cnt   <= '0;
            data_vld <= 1'b0;
            addr_vld <= issue_start;
            if (issue_start) begin
                ref_addr_out <= '0;
                rd_issued    <= PTR_ONE;
            end else begin
                rd_issued    <= '0;
            end
        end else begin
            addr_vld <= issue;
            data_vld <= addr_vld && running;
            if (issue) begin
                ref_addr_out <= rd_issued[REFMEM_PTR_WIDTH-1:0];
                rd_issued    <= rd_issued + PTR_ONE;
            end
            if (wren) wr_cnt <= wr_cnt + PTR_ONE;
        end
    end

    dtw_ref_fwft_buf #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .push      (push),
        .push_data (ref_data_in),
        .pop       (wren),
        .flush     (abort),
        .head_data (sink_fifo_data_out),
        .count     (buf_count),
        .empty     (buf_empty),
        .full      (buf_full)
    );

`ifdef DTW_REF_READER_CKSUM_EN
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)   cksum_out <= '0;
        else if (start) cksum_out <= '0;
        else if (wren)  cksum_out <= cksum_out + 32'(sink_fifo_data_out);
    end
`endif

    assign sink_fifo_wren_out = wren;
    assign busy_out           = (state == STREAM) || (state == DRAIN);
    assign done_out           = (state == DONE);
    assign dbg_state          = state;
    assign dbg_word_cnt       = 32'(wr_cnt);

endmodule
